// File: rtl/bcd_convert_sched_pkg.sv
// Shared constants, state encoding and helpers for the
// time-shared binary-to-BCD converter.
package bcd_convert_sched_pkg;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;
   localparam logic [3:0] ADD3_VAL    = 4'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Largest value representable in 'digits' decimal digits (digits <= 19).
   function automatic logic [63:0] max_bcd_value(input int digits);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < digits; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

endpackage

// File: rtl/bcd_convert_sched_dabble_step.sv
// One shift-and-add-3 iteration: adjust every digit >= 5,
// then shift left by one, pulling in the next binary bit.
module bcd_dabble_step
   import bcd_convert_sched_pkg::*;
#(
   parameter int DIGITS = 8
) (
   input  logic [BCD_DIGIT_W*DIGITS-1:0] acc_i,
   input  logic                          msb_i,
   output logic [BCD_DIGIT_W*DIGITS-1:0] acc_o
);

   localparam int AW = BCD_DIGIT_W * DIGITS;

   logic [AW-1:0] adj;

   always_comb begin
      adj = acc_i;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc_i[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= ADD3_THRESH) begin
            adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] =
               acc_i[d*BCD_DIGIT_W +: BCD_DIGIT_W] + ADD3_VAL;
         end
      end
   end

   assign acc_o = {adj[AW-2:0], msb_i};

endmodule

// File: rtl/bcd_convert_sched.sv
// Round-robin scheduler sharing one sequential binary-to-BCD
// engine among NREQ requesters; results are tagged with the id.
module bcd_convert_sched
   import bcd_convert_sched_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int WIDTH  = 32,
   parameter int DIGITS = 8,
   parameter int IDW    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_hex,
   output logic [NREQ-1:0]         req_ready,
   output logic                    bcd_valid,
   output logic [4*DIGITS-1:0]     bcd_out,
   output logic [IDW-1:0]          bcd_id,
   output logic                    bcd_ovf,
   output logic                    busy
);

   localparam int          AW      = BCD_DIGIT_W * DIGITS;
   localparam int          CW      = $clog2(WIDTH + 1);
   localparam logic [63:0] MAX_VAL = max_bcd_value(DIGITS);
   localparam logic [CW-1:0] LAST_IT = CW'(WIDTH - 1);

   state_e              state_q, state_d;
   logic [IDW-1:0]      rr_q, rr_d;
   logic [IDW-1:0]      id_q, id_d;
   logic [WIDTH-1:0]    shreg_q, shreg_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                bcd_valid_q, bcd_valid_d;
   logic [AW-1:0]       bcd_out_q, bcd_out_d;
   logic [IDW-1:0]      bcd_id_q, bcd_id_d;
   logic                bcd_ovf_q, bcd_ovf_d;

   logic                grant;
   logic [IDW-1:0]      win;
   logic [WIDTH-1:0]    hex_sel;
   logic [AW-1:0]       acc_step;
   int                  idx;

   bcd_dabble_step #(
      .DIGITS (DIGITS)
   ) u_step (
      .acc_i (acc_q),
      .msb_i (shreg_q[WIDTH-1]),
      .acc_o (acc_step)
   );

   // Scan from the lowest offset last so the nearest index at/above rr wins.
   always_comb begin
      grant = 1'b0;
      win   = '0;
      idx   = 0;
      if (!rst && state_q == ST_IDLE) begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
               grant = 1'b1;
               win   = IDW'(idx);
            end
         end
      end
      req_ready = grant ? (NREQ'(1) << win) : '0;
      hex_sel   = req_hex[int'(win)*WIDTH +: WIDTH];
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      id_d        = id_q;
      shreg_d     = shreg_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      bcd_valid_d = 1'b0;
      bcd_out_d   = bcd_out_q;
      bcd_id_d    = bcd_id_q;
      bcd_ovf_d   = bcd_ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_SHIFT;
               id_d    = win;
               rr_d    = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
               shreg_d = hex_sel;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 64'(hex_sel) > MAX_VAL;
            end
         end
         ST_SHIFT: begin
            acc_d   = acc_step;
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_IT) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            bcd_valid_d = 1'b1;
            bcd_out_d   = ovf_q ? {DIGITS{4'h9}} : acc_q;
            bcd_id_d    = id_q;
            bcd_ovf_d   = ovf_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_q        <= '0;
         id_q        <= '0;
         shreg_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         bcd_valid_q <= 1'b0;
         bcd_out_q   <= '0;
         bcd_id_q    <= '0;
         bcd_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         shreg_q     <= shreg_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         bcd_valid_q <= bcd_valid_d;
         bcd_out_q   <= bcd_out_d;
         bcd_id_q    <= bcd_id_d;
         bcd_ovf_q   <= bcd_ovf_d;
      end
   end

   assign bcd_valid = bcd_valid_q;
   assign bcd_out   = bcd_out_q;
   assign bcd_id    = bcd_id_q;
   assign bcd_ovf   = bcd_ovf_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Scoreboard bench for bcd_convert_sched: a decimal reference model
// predicts grants, busy and tagged results; a monitor checks them.
module tb_bcd_convert_sched;

   localparam int NREQ   = 2;
   localparam int WIDTH  = 32;
   localparam int DIGITS = 8;
   localparam int IDW    = 1;
   localparam int LAT    = WIDTH + 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_hex = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  bcd_valid;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [IDW-1:0]        bcd_id;
   logic                  bcd_ovf;
   logic                  busy;

   typedef struct {
      logic [31:0] bcd;
      int          id;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   n_checks   = 0;
   int   n_errors   = 0;
   int   cyc        = 0;
   int   rr_m       = 0;
   int   next_ok    = 0;
   int   busy_until = -1;

   bcd_convert_sched #(
      .NREQ   (NREQ),
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS),
      .IDW    (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_hex   (req_hex),
      .req_ready (req_ready),
      .bcd_valid (bcd_valid),
      .bcd_out   (bcd_out),
      .bcd_id    (bcd_id),
      .bcd_ovf   (bcd_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_bcd(input logic [31:0] v);
      logic [31:0]     r;
      longint unsigned x;
      r = '0;
      x = longint'(v);
      if (x > 64'd99999999) return 32'h99999999;
      for (int d = 0; d < DIGITS; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] gen_val();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return $urandom_range(0, 99);
         2:       return 32'd99999990 + $urandom_range(0, 20);
         default: return $urandom_range(0, 99999999);
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference model: predicts grant, busy window and queued result.
   always @(negedge clk) begin : model
      logic [NREQ-1:0] exp_rdy;
      logic [31:0]     v;
      int              w;
      exp_t            e;
      exp_rdy = '0;
      w = -1;
      if (!rst && cyc >= next_ok) begin
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req_valid[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
         end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (!rst) chk("busy", 64'(busy), 64'(cyc <= busy_until));
      if (rst) begin
         sb.delete();
         rr_m       = 0;
         next_ok    = cyc + 1;
         busy_until = cyc;
      end else if (w >= 0) begin
         v     = req_hex[w*WIDTH +: WIDTH];
         e.bcd = ref_bcd(v);
         e.id  = w;
         e.ovf = (v > 32'd99999999);
         e.due = cyc + LAT;
         sb.push_back(e);
         rr_m       = (w + 1) % NREQ;
         next_ok    = cyc + LAT;
         busy_until = cyc + LAT - 1;
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bcd_valid) begin
         if (sb.size() == 0) begin
            fail_now("unexpected bcd_valid");
         end else begin
            e = sb.pop_front();
            chk("bcd_out", 64'(bcd_out), 64'(e.bcd));
            chk("bcd_id", 64'(bcd_id), 64'(e.id));
            chk("bcd_ovf", 64'(bcd_ovf), 64'(e.ovf));
            chk("latency_cycle", 64'(cyc), 64'(e.due));
         end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
         fail_now("result timeout");
         void'(sb.pop_front());
      end
   end

   task automatic drive_req(input int i, input logic [31:0] v);
      req_hex[i*WIDTH +: WIDTH] = v;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_grant(input int i);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (req_valid[i] && req_ready[i]) got = 1'b1;
      end
      if (!got) fail_now("grant timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [31:0] v);
      drive_req(i, v);
      wait_grant(i);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
      if (sb.size() != 0) fail_now("drain timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero();
      @(negedge clk);
      chk("rst_bcd_valid", 64'(bcd_valid), 64'd0);
      chk("rst_bcd_out", 64'(bcd_out), 64'd0);
      chk("rst_bcd_id", 64'(bcd_id), 64'd0);
      chk("rst_bcd_ovf", 64'(bcd_ovf), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Expect grants in order 0,1,0,1...; either drop or reload after each.
   task automatic run_grants(input int n, input bit reload);
      int              g;
      logic [NREQ-1:0] hs;
      g = 0;
      for (int c = 0; c < 40 * n + 40 && g < n; c++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         if (hs != '0) begin
            chk("grant_order", 64'(hs), 64'(1 << (g % NREQ)));
            g++;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
               if (hs[i]) begin
                  if (reload) req_hex[i*WIDTH +: WIDTH] = gen_val();
                  else req_valid[i] = 1'b0;
               end
            end
         end
      end
      if (g < n) begin
         fail_now("grant sequence timeout");
         @(posedge clk);
         #1;
      end
      req_valid = '0;
   endtask

   initial begin : stim
      logic [NREQ-1:0] hs;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_zero();

      drive_req(0, 32'd2048);
      drive_req(1, 32'd4096);
      run_grants(2, 1'b0);
      wait_drain();

      pulse_rst();
      drive_req(0, gen_val());
      drive_req(1, gen_val());
      run_grants(4, 1'b1);
      wait_drain();

      send(0, 32'd12);
      wait_drain();
      send(1, 32'd99999999);
      wait_drain();
      send(1, 32'd0);
      wait_drain();
      send(0, 32'd100000000);
      wait_drain();
      send(0, 32'hFFFFFFFF);
      wait_drain();

      send(0, 32'd12345678);
      repeat (10) @(posedge clk);
      #1;
      pulse_rst();
      check_zero();
      send(0, 32'd7);
      wait_drain();

      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 2) == 0);
               req_hex[i*WIDTH +: WIDTH] = gen_val();
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
      wait_drain();
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
